// File: rtl/ofifo_deskew.sv
// Output deskew FIFO bank: each column fills independently, and the reader pops whole rows.
// Define OFIFO_OVF_FLAG_EN to add a sticky o_overflow flag for writes dropped on a full column.
module ofifo_deskew #(
   parameter int col   = 8,
   parameter int bw    = 16,
   parameter int depth = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [col*bw-1:0] in,
   input  logic [col-1:0]    wr,
   input  logic              rd,
   output logic [col*bw-1:0] out,
   output logic              o_valid,
   output logic              o_full,
`ifdef OFIFO_OVF_FLAG_EN
   output logic              o_ready,
   output logic              o_overflow
`else
   output logic              o_ready
`endif
);

   localparam int aw = $clog2(depth);
   localparam logic [aw:0] ptr_one = (aw+1)'(1);

   logic [bw-1:0] mem [col][depth];
   logic [aw:0]   wptr [col];
   logic [aw:0]   rptr [col];
   logic [col-1:0] empty;
   logic [col-1:0] full;
   logic           rd_accept;

   // A column is full when the low bits match but the pointers are one lap apart.
   always_comb begin
      empty = '0;
      full  = '0;
      for (int j = 0; j < col; j++) begin
         empty[j] = (wptr[j] == rptr[j]);
         full[j]  = (wptr[j][aw-1:0] == rptr[j][aw-1:0]) && (wptr[j][aw] != rptr[j][aw]);
      end
   end

   assign o_valid   = &(~empty);
   assign o_full    = |full;
   assign o_ready   = ~o_full;
   assign rd_accept = rd & o_valid;

   // Storage has no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      for (int j = 0; j < col; j++) begin
         if (!reset && wr[j] && !full[j])
            mem[j][wptr[j][aw-1:0]] <= in[j*bw +: bw];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out <= '0;
         for (int j = 0; j < col; j++) begin
            wptr[j] <= '0;
            rptr[j] <= '0;
         end
      end else begin
         for (int j = 0; j < col; j++) begin
            if (wr[j] && !full[j])
               wptr[j] <= wptr[j] + ptr_one;
            if (rd_accept) begin
               rptr[j]           <= rptr[j] + ptr_one;
               out[j*bw +: bw]   <= mem[j][rptr[j][aw-1:0]];
            end
         end
      end
   end

`ifdef OFIFO_OVF_FLAG_EN
   always_ff @(posedge clk) begin
      if (reset)
         o_overflow <= 1'b0;
      else if (|(wr & full))
         o_overflow <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ofifo_deskew.sv
// Directed self-checking bench for ofifo_deskew.
// Covers reset, staggered fill, pointer wrap, the full boundary, simultaneous rd/wr and mid-stream reset.
module tb_ofifo_deskew;

   localparam int COL = 8;
   localparam int BW  = 16;
   localparam int DEP = 64;

   logic               clk = 1'b0;
   logic               reset;
   logic [COL*BW-1:0]  in;
   logic [COL-1:0]     wr;
   logic               rd;
   logic [COL*BW-1:0]  out;
   logic               o_valid;
   logic               o_full;
   logic               o_ready;
`ifdef OFIFO_OVF_FLAG_EN
   logic               o_overflow;
`endif

   int checks = 0;
   int errors = 0;

   ofifo_deskew #(.col(COL), .bw(BW), .depth(DEP)) dut (
      .clk(clk),
      .reset(reset),
      .in(in),
      .wr(wr),
      .rd(rd),
      .out(out),
      .o_valid(o_valid),
      .o_full(o_full),
`ifdef OFIFO_OVF_FLAG_EN
      .o_ready(o_ready),
      .o_overflow(o_overflow)
`else
      .o_ready(o_ready)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr    = '0;
      rd    = 1'b0;
      in    = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out !== '0) begin errors++; $display("[TB] FAIL reset_out: got %h want 0", out); end
      checks++;
      if ({o_valid, o_full, o_ready} !== 3'b001) begin
         errors++; $display("[TB] FAIL reset_flags: got v%b f%b r%b want v0 f0 r1", o_valid, o_full, o_ready);
      end
`ifdef OFIFO_OVF_FLAG_EN
      checks++;
      if (o_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovf: got %b want 0", o_overflow); end
`endif
      rd = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out !== '0 || {o_valid, o_full, o_ready} !== 3'b001) begin
            errors++; $display("[TB] FAIL idle_rd%0d: got out %h v%b f%b r%b want out 0 v0 f0 r1", i, out, o_valid, o_full, o_ready);
         end
      end
      rd = 1'b0;
   endtask

   task automatic test_stagger();
      logic [COL*BW-1:0] exp;
      logic [COL*BW-1:0] held;
      do_reset();
      exp = '0;
      for (int j = 0; j < COL; j++) begin
         wr = '0;
         wr[j] = 1'b1;
         in = '0;
         in[j*BW +: BW] = 16'h0100 + 16'(j);
         exp[j*BW +: BW] = 16'h0100 + 16'(j);
         tick();
         checks++;
         if (o_valid !== (j == COL-1)) begin
            errors++; $display("[TB] FAIL stagger_valid col%0d: got %b want %b", j, o_valid, (j == COL-1));
         end
      end
      wr = '0;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++;
      if (out !== exp) begin errors++; $display("[TB] FAIL stagger_row: got %h want %h", out, exp); end
      checks++;
      if (o_valid !== 1'b0) begin errors++; $display("[TB] FAIL stagger_empty: got %b want 0", o_valid); end
      held = exp;
      rd = 1'b1;
      tick();
      rd = 1'b0;
      checks++;
      if (out !== held) begin errors++; $display("[TB] FAIL stagger_hold: got %h want %h", out, held); end
   endtask

   task automatic test_wrap();
      int rows_out;
      int r;
      logic did_rd;
      logic [COL*BW-1:0] exp;
      do_reset();
      rows_out = 0;
      for (int c = 0; c < 225; c++) begin
         wr = '0;
         in = '0;
         for (int j = 0; j < COL; j++) begin
            r = c - j;
            if (r >= 0 && r < 200) begin
               wr[j] = 1'b1;
               in[j*BW +: BW] = 16'(r*8 + j);
            end
         end
         did_rd = o_valid;
         rd = did_rd;
         tick();
         checks++;
         if (o_full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_full cycle%0d: got %b want 0", c, o_full); end
         if (did_rd) begin
            for (int j = 0; j < COL; j++) exp[j*BW +: BW] = 16'(rows_out*8 + j);
            checks++;
            if (out !== exp) begin errors++; $display("[TB] FAIL wrap_row%0d: got %h want %h", rows_out, out, exp); end
            rows_out++;
         end
      end
      wr = '0;
      rd = 1'b0;
      checks++;
      if (rows_out != 200) begin errors++; $display("[TB] FAIL wrap_count: got %0d want 200", rows_out); end
   endtask

   task automatic test_full();
      do_reset();
      wr = 8'h08;
      for (int i = 0; i < DEP; i++) begin
         in = '0;
         in[3*BW +: BW] = 16'h3000 + 16'(i);
         tick();
      end
      checks++;
      if ({o_valid, o_full, o_ready} !== 3'b010) begin
         errors++; $display("[TB] FAIL full_flags: got v%b f%b r%b want v0 f1 r0", o_valid, o_full, o_ready);
      end
      in[3*BW +: BW] = 16'hDEAD;
      tick();
      checks++;
      if (o_full !== 1'b1) begin errors++; $display("[TB] FAIL full_hold: got %b want 1", o_full); end
`ifdef OFIFO_OVF_FLAG_EN
      checks++;
      if (o_overflow !== 1'b1) begin errors++; $display("[TB] FAIL full_ovf: got %b want 1", o_overflow); end
`endif
      wr = 8'hF7;
      for (int i = 0; i < DEP; i++) begin
         for (int j = 0; j < COL; j++) in[j*BW +: BW] = 16'(j*256 + i);
         tick();
      end
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL full_allvalid: got %b want 1", o_valid); end
      for (int i = 0; i < DEP; i++) begin
         rd = 1'b1;
         wr = (i == 0) ? 8'h08 : 8'h00;
         in = '0;
         in[3*BW +: BW] = 16'hBEEF;
         tick();
         checks++;
         if (out[3*BW +: BW] !== 16'h3000 + 16'(i) || out[0 +: BW] !== 16'(i)) begin
            errors++; $display("[TB] FAIL full_read%0d: got c3 %h c0 %h want c3 %h c0 %h",
                               i, out[3*BW +: BW], out[0 +: BW], 16'h3000 + 16'(i), 16'(i));
         end
      end
      rd = 1'b0;
      wr = '0;
      checks++;
      if ({o_valid, o_full} !== 2'b00) begin errors++; $display("[TB] FAIL full_drained: got v%b f%b want v0 f0", o_valid, o_full); end
   endtask

   task automatic test_back_to_back();
      logic [COL*BW-1:0] row_a;
      logic [COL*BW-1:0] row_b;
      do_reset();
      for (int j = 0; j < COL; j++) begin
         row_a[j*BW +: BW] = 16'hA000 + 16'(j);
         row_b[j*BW +: BW] = 16'hB000 + 16'(j);
      end
      wr = 8'hFF;
      in = row_a;
      tick();
      checks++;
      if (o_valid !== 1'b1) begin errors++; $display("[TB] FAIL simul_prefill: got %b want 1", o_valid); end
      rd = 1'b1;
      in = row_b;
      tick();
      wr = '0;
      checks++;
      if (out !== row_a || o_valid !== 1'b1) begin
         errors++; $display("[TB] FAIL simul_old: got %h v%b want %h v1", out, o_valid, row_a);
      end
      tick();
      rd = 1'b0;
      checks++;
      if (out !== row_b || o_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL simul_new: got %h v%b want %h v0", out, o_valid, row_b);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      wr = 8'hFF;
      for (int r = 0; r < 5; r++) begin
         for (int j = 0; j < COL; j++) in[j*BW +: BW] = 16'h5000 + 16'(r*16 + j);
         tick();
      end
      rd = 1'b1;
      wr = '0;
      tick();
      checks++;
      if (out[0 +: BW] !== 16'h5000) begin errors++; $display("[TB] FAIL mid_pre: got %h want 5000", out[0 +: BW]); end
      reset = 1'b1;
      rd = 1'b1;
      wr = 8'hFF;
      in = {COL{16'hEEEE}};
      tick();
      reset = 1'b0;
      wr = '0;
      checks++;
      if (out !== '0 || o_valid !== 1'b0) begin
         errors++; $display("[TB] FAIL mid_reset: got %h v%b want 0 v0", out, o_valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (out !== '0 || o_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL mid_discard%0d: got %h v%b want 0 v0", i, out, o_valid);
         end
      end
      rd = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1;
      wr = '0;
      rd = 1'b0;
      in = '0;
      test_reset();
      test_stagger();
      test_wrap();
      test_full();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
